// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit:
// FSM states, ALU operation codes, mux-select encodings and opcodes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALWB    = 4'd12,
        S_UI       = 4'd13,
        S_TRAP     = 4'd14
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ITYPE = 2'b11
    } aluop_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Strobes ending in _on_done / _on_taken are qualified later by
    // mem_done or the branch condition; everything else is pure Moore.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_on_done;
        logic       pc_write;
        logic       pc_on_done;
        logic       pc_on_taken;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        aluop_t     alu_op;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

    function automatic ctrl_t ctrl_of(input state_t s, input logic [6:0] op);
        ctrl_t c;
        c = '0;
        c.alu_op = ALUOP_ADD;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.ir_on_done = 1'b1;
                c.pc_on_done = 1'b1;
                c.result_src = RES_ALURES;
                c.alu_src_a  = SRCA_PC;
                c.alu_src_b  = SRCB_FOUR;
            end
            S_DECODE: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_B;
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = op[5] ? IMM_S : IMM_I;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_RTYPE;
            end
            S_EXECI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_I;
                c.alu_op    = ALUOP_ITYPE;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a   = SRCA_RD1;
                c.alu_src_b   = SRCB_RD2;
                c.alu_op      = ALUOP_SUB;
                c.pc_on_taken = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_write  = 1'b1;
            end
            S_JALR: begin
                c.alu_src_a  = SRCA_RD1;
                c.alu_src_b  = SRCB_IMM;
                c.imm_src    = IMM_I;
                c.result_src = RES_ALURES;
                c.pc_write   = 1'b1;
            end
            S_JALWB: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALURES;
                c.reg_write  = 1'b1;
            end
            S_UI: begin
                c.alu_src_a = (op == OP_LUI) ? SRCA_ZERO : SRCA_OLDPC;
                c.alu_src_b = SRCB_IMM;
                c.imm_src   = IMM_U;
            end
            default: begin
                c.alu_op = ALUOP_ADD;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aludec_mc.sv
// ALU operation decoder: maps the operation class chosen by the FSM plus
// funct3/funct7b5 onto the ALUControl code (upper bits zero-extended).
module aludec_mc
    import multicycle_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [1:0]           alu_op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    output logic [ALUCTRL_W-1:0] alu_control
);

    logic [3:0] code_s;
    logic       is_r_s;

    assign is_r_s = (aluop_t'(alu_op) == ALUOP_RTYPE);

    // Register-register and immediate forms share the funct3 table; only
    // sub needs the R form, while sra/srai both use funct7b5.
    always_comb begin
        code_s = ALU_ADD;
        case (aluop_t'(alu_op))
            ALUOP_ADD: code_s = ALU_ADD;
            ALUOP_SUB: code_s = ALU_SUB;
            ALUOP_RTYPE, ALUOP_ITYPE: begin
                case (funct3)
                    3'b000: begin
                        if (is_r_s && funct7b5) code_s = ALU_SUB;
                        else                    code_s = ALU_ADD;
                    end
                    3'b001: code_s = ALU_SLL;
                    3'b010: code_s = ALU_SLT;
                    3'b011: code_s = ALU_SLTU;
                    3'b100: code_s = ALU_XOR;
                    3'b101: begin
                        if (funct7b5) code_s = ALU_SRA;
                        else          code_s = ALU_SRL;
                    end
                    3'b110: code_s = ALU_OR;
                    3'b111: code_s = ALU_AND;
                    default: code_s = ALU_ADD;
                endcase
            end
            default: code_s = ALU_ADD;
        endcase
    end

    assign alu_control = ALUCTRL_W'(code_s);

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V datapath with memory handshake.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes in a sticky TRAP state.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int USE_READY = 1,
    parameter int MEM_LAT   = 1,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 Zero,
    input  logic                 Neg,
    input  logic                 Carry,
    input  logic                 Ovf,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 MemWrite,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           immsrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 illegal
);

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    state_t                 state_r;
    state_t                 state_n_s;
    ctrl_t                  ctrl_r;
    ctrl_t                  ctrl_n_s;
    logic [3:0]             cnt_r;
    logic                   mem_done_s;
    logic                   taken_s;
    logic [ALUCTRL_W-1:0]   alu_n_s;
    logic [ALUCTRL_W-1:0]   alu_r;

    assign mem_done_s = (USE_READY != 0) ? mem_ready : (cnt_r == LAT_LAST);

    // Branch condition from the flags of the SUB performed in BRANCH.
    always_comb begin
        taken_s = 1'b0;
        case (funct3)
            3'b000:  taken_s = Zero;
            3'b001:  taken_s = ~Zero;
            3'b100:  taken_s = Neg ^ Ovf;
            3'b101:  taken_s = ~(Neg ^ Ovf);
            3'b110:  taken_s = ~Carry;
            3'b111:  taken_s = Carry;
            default: taken_s = 1'b0;
        endcase
    end

    // Next-state sequencing.
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            S_FETCH: begin
                if (mem_done_s) state_n_s = S_DECODE;
                else            state_n_s = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_n_s = S_MEMADR;
                    OP_RTYPE:          state_n_s = S_EXECR;
                    OP_ITYPE:          state_n_s = S_EXECI;
                    OP_BR:             state_n_s = S_BRANCH;
                    OP_JAL:            state_n_s = S_JAL;
                    OP_JALR:           state_n_s = S_JALR;
                    OP_LUI, OP_AUIPC:  state_n_s = S_UI;
`ifdef ILLEGAL_TRAP_EN
                    default:           state_n_s = S_TRAP;
`else
                    default:           state_n_s = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                if (op[5]) state_n_s = S_MEMWRITE;
                else       state_n_s = S_MEMREAD;
            end
            S_MEMREAD: begin
                if (mem_done_s) state_n_s = S_MEMWB;
                else            state_n_s = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (mem_done_s) state_n_s = S_FETCH;
                else            state_n_s = S_MEMWRITE;
            end
            S_EXECR, S_EXECI, S_JAL, S_UI: state_n_s = S_ALUWB;
            S_JALR:                        state_n_s = S_JALWB;
            S_TRAP:                        state_n_s = S_TRAP;
            default:                       state_n_s = S_FETCH;
        endcase
    end

    assign ctrl_n_s = ctrl_of(state_n_s, op);

    aludec_mc #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
        .alu_op      (ctrl_n_s.alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_control (alu_n_s)
    );

    // State and Moore outputs are registered together, decoded from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
            ctrl_r  <= ctrl_of(S_FETCH, 7'b0000000);
            alu_r   <= ALUCTRL_W'(ALU_ADD);
        end else begin
            state_r <= state_n_s;
            ctrl_r  <= ctrl_n_s;
            alu_r   <= alu_n_s;
        end
    end

    // Fixed-latency wait counter; restarts at zero on every memory-state entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 4'd0;
        end else if ((USE_READY == 0) && is_mem_state(state_r) && !mem_done_s) begin
            cnt_r <= cnt_r + 4'd1;
        end else begin
            cnt_r <= 4'd0;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky illegal flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_r <= 1'b0;
        end else begin
            illegal_r <= (state_n_s == S_TRAP);
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    // Strobes are held low for the whole reset pulse so no access leaks out.
    assign mem_req    = ctrl_r.mem_req & ~reset;
    assign MemWrite   = ctrl_r.mem_write & ~reset;
    assign AdrSrc     = ctrl_r.adr_src;
    assign IRWrite    = ctrl_r.ir_on_done & mem_done_s & ~reset;
    assign PCWrite    = (ctrl_r.pc_write
                        | (ctrl_r.pc_on_done & mem_done_s)
                        | (ctrl_r.pc_on_taken & taken_s)) & ~reset;
    assign RegWrite   = ctrl_r.reg_write & ~reset;
    assign ResultSrc  = ctrl_r.result_src;
    assign ALUSrcA    = ctrl_r.alu_src_a;
    assign ALUSrcB    = ctrl_r.alu_src_b;
    assign immsrc     = ctrl_r.imm_src;
    assign ALUControl = alu_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench for multicycle_controller: a ready-handshake instance and a
// fixed-latency (MEM_LAT=3) instance, each checked against a per-instruction phase model.
module tb_multicycle_controller;

    typedef enum int {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE, T_EXECR,
        T_EXECI, T_ALUWB, T_BRANCH, T_JAL, T_JALR, T_JALWB, T_UI, T_TRAP, T_RESET
    } step_e;

    localparam logic [6:0] O_LOAD  = 7'b0000011;
    localparam logic [6:0] O_STORE = 7'b0100011;
    localparam logic [6:0] O_R     = 7'b0110011;
    localparam logic [6:0] O_I     = 7'b0010011;
    localparam logic [6:0] O_BR    = 7'b1100011;
    localparam logic [6:0] O_JAL   = 7'b1101111;
    localparam logic [6:0] O_JALR  = 7'b1100111;
    localparam logic [6:0] O_LUI   = 7'b0110111;
    localparam logic [6:0] O_AUIPC = 7'b0010111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero, Neg, Carry, Ovf;
    logic       mem_ready_a, mem_ready_b;

    logic       mem_req_a, MemWrite_a, AdrSrc_a, IRWrite_a, PCWrite_a, RegWrite_a, illegal_a;
    logic [1:0] ResultSrc_a, ALUSrcA_a, ALUSrcB_a;
    logic [2:0] immsrc_a;
    logic [3:0] ALUControl_a;
    logic       mem_req_b, MemWrite_b, AdrSrc_b, IRWrite_b, PCWrite_b, RegWrite_b, illegal_b;
    logic [1:0] ResultSrc_b, ALUSrcA_b, ALUSrcB_b;
    logic [2:0] immsrc_b;
    logic [4:0] ALUControl_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.USE_READY(1), .MEM_LAT(1), .ALUCTRL_W(4)) dut_a (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .mem_ready(mem_ready_a),
        .mem_req(mem_req_a), .MemWrite(MemWrite_a), .AdrSrc(AdrSrc_a), .IRWrite(IRWrite_a),
        .PCWrite(PCWrite_a), .RegWrite(RegWrite_a), .ResultSrc(ResultSrc_a),
        .ALUSrcA(ALUSrcA_a), .ALUSrcB(ALUSrcB_a), .immsrc(immsrc_a),
        .ALUControl(ALUControl_a), .illegal(illegal_a)
    );

    multicycle_controller #(.USE_READY(0), .MEM_LAT(3), .ALUCTRL_W(5)) dut_b (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .mem_ready(mem_ready_b),
        .mem_req(mem_req_b), .MemWrite(MemWrite_b), .AdrSrc(AdrSrc_b), .IRWrite(IRWrite_b),
        .PCWrite(PCWrite_b), .RegWrite(RegWrite_b), .ResultSrc(ResultSrc_b),
        .ALUSrcA(ALUSrcA_b), .ALUSrcB(ALUSrcB_b), .immsrc(immsrc_b),
        .ALUControl(ALUControl_b), .illegal(illegal_b)
    );

    task automatic check_vec(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [20:0] obs(input bit which);
        if (which)
            return {mem_req_b, MemWrite_b, AdrSrc_b, IRWrite_b, PCWrite_b, RegWrite_b,
                    ResultSrc_b, ALUSrcA_b, ALUSrcB_b, immsrc_b, ALUControl_b, illegal_b};
        return {mem_req_a, MemWrite_a, AdrSrc_a, IRWrite_a, PCWrite_a, RegWrite_a,
                ResultSrc_a, ALUSrcA_a, ALUSrcB_a, immsrc_a, 1'b0, ALUControl_a, illegal_a};
    endfunction

    function automatic logic [4:0] alu_model(input bit r_form);
        logic [3:0] tab [8];
        logic [3:0] code;
        tab = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        code = tab[funct3];
        if (r_form && funct3 == 3'd0 && funct7b5) code = 4'd1;
        if (funct3 == 3'd5 && funct7b5) code = 4'd9;
        return {1'b0, code};
    endfunction

    // Expected outputs for one cycle of a given instruction phase.
    function automatic logic [20:0] exp_vec(input step_e s, input logic done, input logic tk);
        logic       req, mw, adr, irw, pcw, rw, ill;
        logic [1:0] rs, sa, sb;
        logic [2:0] imm;
        logic [4:0] alu;
        {req, mw, adr, irw, pcw, rw, ill} = 7'd0;
        rs = 2'd0; sa = 2'd0; sb = 2'd0; imm = 3'd0; alu = 5'd0;
        case (s)
            T_RESET:    begin rs = 2'b10; sb = 2'b10; end
            T_FETCH:    begin req = 1'b1; irw = done; pcw = done; rs = 2'b10; sb = 2'b10; end
            T_DECODE:   begin sa = 2'b01; sb = 2'b01; imm = 3'b010; end
            T_MEMADR:   begin sa = 2'b10; sb = 2'b01; imm = (op == O_STORE) ? 3'b001 : 3'b000; end
            T_MEMREAD:  begin req = 1'b1; adr = 1'b1; end
            T_MEMWB:    begin rs = 2'b01; rw = 1'b1; end
            T_MEMWRITE: begin req = 1'b1; adr = 1'b1; mw = 1'b1; end
            T_EXECR:    begin sa = 2'b10; alu = alu_model(1'b1); end
            T_EXECI:    begin sa = 2'b10; sb = 2'b01; alu = alu_model(1'b0); end
            T_ALUWB:    begin rw = 1'b1; end
            T_BRANCH:   begin sa = 2'b10; alu = 5'd1; pcw = tk; end
            T_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
            T_JALR:     begin sa = 2'b10; sb = 2'b01; rs = 2'b10; pcw = 1'b1; end
            T_JALWB:    begin sa = 2'b01; sb = 2'b10; rs = 2'b10; rw = 1'b1; end
            T_UI:       begin sa = (op == O_LUI) ? 2'b11 : 2'b01; sb = 2'b01; imm = 3'b100; end
            T_TRAP:     begin ill = 1'b1; end
            default:    begin ill = 1'b0; end
        endcase
        return {req, mw, adr, irw, pcw, rw, rs, sa, sb, imm, alu, ill};
    endfunction

    // Runs one instruction on the selected instance, checking every cycle.
    task automatic run_instr(input bit which, input logic [6:0] o, input logic [2:0] f3,
                             input logic f7, input logic [31:0] a, input logic [31:0] b,
                             input bit rst_mw, input int fetch_cycles);
        step_e       seq[$];
        logic [31:0] diff;
        logic        tk, done;
        int          n;
        string       tag;
        op = o; funct3 = f3; funct7b5 = f7;
        diff = a - b;
        Zero = (diff == 32'd0); Neg = diff[31]; Carry = (a >= b);
        Ovf = (a[31] != b[31]) && (diff[31] != a[31]);
        case (f3)
            3'd0: tk = (a == b);
            3'd1: tk = (a != b);
            3'd4: tk = ($signed(a) < $signed(b));
            3'd5: tk = ($signed(a) >= $signed(b));
            3'd6: tk = (a < b);
            3'd7: tk = (a >= b);
            default: tk = 1'b0;
        endcase
        seq.push_back(T_FETCH);
        seq.push_back(T_DECODE);
        case (o)
            O_LOAD:         begin seq.push_back(T_MEMADR); seq.push_back(T_MEMREAD); seq.push_back(T_MEMWB); end
            O_STORE:        begin seq.push_back(T_MEMADR); seq.push_back(T_MEMWRITE); end
            O_R:            begin seq.push_back(T_EXECR); seq.push_back(T_ALUWB); end
            O_I:            begin seq.push_back(T_EXECI); seq.push_back(T_ALUWB); end
            O_BR:           seq.push_back(T_BRANCH);
            O_JAL:          begin seq.push_back(T_JAL); seq.push_back(T_ALUWB); end
            O_JALR:         begin seq.push_back(T_JALR); seq.push_back(T_JALWB); end
            O_LUI, O_AUIPC: begin seq.push_back(T_UI); seq.push_back(T_ALUWB); end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                seq.push_back(T_TRAP); seq.push_back(T_TRAP); seq.push_back(T_TRAP);
`endif
            end
        endcase
        foreach (seq[i]) begin
            if (seq[i] == T_FETCH || seq[i] == T_MEMREAD || seq[i] == T_MEMWRITE) begin
                if (which) n = 3;
                else if (seq[i] == T_FETCH && fetch_cycles != 0) n = fetch_cycles;
                else if (rst_mw && seq[i] == T_MEMWRITE) n = 3;
                else n = $urandom_range(1, 3);
            end else begin
                n = 1;
            end
            for (int c = 0; c < n; c++) begin
                done = (c == n - 1);
                mem_ready_a = which ? 1'($urandom) : ((n > 1 || seq[i] == T_FETCH ||
                              seq[i] == T_MEMREAD || seq[i] == T_MEMWRITE) ? done : 1'($urandom));
                mem_ready_b = 1'($urandom);
                tag = $sformatf("%s.%s.%0d op=%b f3=%0d", which ? "lat" : "rdy", seq[i].name(), c, o, f3);
                @(negedge clk);
                check_vec(tag, obs(which), exp_vec(seq[i], done, tk));
                if (rst_mw && seq[i] == T_MEMWRITE) begin
                    #2 reset = 1'b1;
                    #1 check_vec({tag, " reset"}, obs(which), exp_vec(T_RESET, 1'b0, 1'b0));
                    @(posedge clk);
                    #1 reset = 1'b0;
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
        if (seq[seq.size() - 1] == T_TRAP) begin
            reset = 1'b1;
            @(negedge clk);
            check_vec("trap_reset", obs(which), exp_vec(T_RESET, 1'b0, 1'b0));
            @(posedge clk);
            #1 reset = 1'b0;
        end
    endtask

    task automatic run_random(input bit which, input int count);
        logic [6:0]  ops [11];
        logic [31:0] a, b;
        ops = '{O_LOAD, O_STORE, O_R, O_I, O_BR, O_JAL, O_JALR, O_LUI, O_AUIPC,
                7'b0000000, 7'b1111111};
        for (int k = 0; k < count; k++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            run_instr(which, ops[$urandom_range(0, 10)], 3'($urandom), 1'($urandom), a, b, 1'b0, 0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check_vec("reset.rdy", obs(1'b0), exp_vec(T_RESET, 1'b0, 1'b0));
        check_vec("reset.lat", obs(1'b1), exp_vec(T_RESET, 1'b0, 1'b0));
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0;
        Zero = 1'b0; Neg = 1'b0; Carry = 1'b0; Ovf = 1'b0;
        mem_ready_a = 1'b0; mem_ready_b = 1'b0;
        do_reset();
        // handshake instance: directed cases first
        run_instr(1'b0, O_R, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 3);
        run_instr(1'b0, O_R, 3'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1);
        run_instr(1'b0, O_I, 3'd5, 1'b1, 32'd0, 32'd0, 1'b0, 2);
        run_instr(1'b0, O_I, 3'd0, 1'b1, 32'd0, 32'd0, 1'b0, 1);
        run_instr(1'b0, O_BR, 3'd1, 1'b0, 32'd7, 32'd7, 1'b0, 1);
        run_instr(1'b0, O_BR, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1);
        run_instr(1'b0, O_BR, 3'd7, 1'b0, 32'd1, 32'd2, 1'b0, 1);
        run_instr(1'b0, O_JALR, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1);
        run_instr(1'b0, O_STORE, 3'd2, 1'b0, 32'd0, 32'd0, 1'b1, 1);
        run_instr(1'b0, O_LUI, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1);
        run_instr(1'b0, 7'b0000000, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1);
        run_random(1'b0, 80);
        // fixed-latency instance
        do_reset();
        run_instr(1'b1, O_LOAD, 3'd2, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        run_instr(1'b1, O_STORE, 3'd2, 1'b0, 32'd0, 32'd0, 1'b0, 0);
        run_random(1'b1, 50);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Parametrised successor to the single-cycle control unit, for the multicycle RISC-V datapath (shared instruction/data memory, IR/OldPC/ALUOut/Data registers).
- A Moore FSM sequences each instruction over 3–5 states.
- Adds a memory ready handshake, all six conditional branches, jalr, lui and auipc.
- Sits between the IR/flag outputs and the multicycle datapath mux selects and write strobes.

Parameters:
USE_READY, 1, 1: memory states wait on mem_ready; 0: fixed-latency wait counter.
MEM_LAT, 1, cycles per memory access when USE_READY=0 (1..15); 1 means single-cycle access.
ALUCTRL_W, 4, width of ALUControl (minimum 4).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
funct7b5  in  1  IR[30]
Zero, Neg, Carry, Ovf  in  1 each  ALU flags from the current SUB
mem_ready  in  1  memory access complete this cycle
mem_req  out  1  memory access active
MemWrite  out  1  store strobe
AdrSrc  out  1  0=PC, 1=Result
IRWrite  out  1  latch IR and OldPC
PCWrite  out  1  PC update strobe (includes taken branch)
RegWrite  out  1  register file write
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=RD1, 11=zero
ALUSrcB  out  2  00=RD2, 01=ImmExt, 10=const 4
immsrc  out  3  I=000, S=001, B=010, J=011, U=100
ALUControl  out  ALUCTRL_W  ALU operation
illegal  out  1  unsupported opcode seen (see Optional Feature)

Behaviour:
- Clocking and reset:
  - One clock domain.
  - reset asynchronously forces state=FETCH and clears the wait counter.
  - While reset=1, all strobes (mem_req, MemWrite, IRWrite, PCWrite, RegWrite) are forced 0 and illegal=0; mux selects show FETCH values.
  - Reset mid-access abandons the access; there is no partial write.
- Memory-done condition (mem_done):
  - USE_READY=1: mem_done = mem_ready.
  - USE_READY=0: a counter counts from entry to a memory state; mem_done fires on the MEM_LAT-th cycle there. MEM_LAT=1 gives done on the first cycle.
- States and outputs (Moore; PCWrite in BRANCH is the only flag-dependent strobe):
  - FETCH: mem_req, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALU ADD, ResultSrc=10.
    - IRWrite and PCWrite are asserted only when mem_done.
    - Stay in FETCH until mem_done, then go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, immsrc=B, ADD (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - 1100111 -> JALR
    - 0110111 or 0010111 -> UI
    - any other -> FETCH
  - MEMADR: RD1+Imm; immsrc=I for loads, S for stores. Go to MEMREAD (op[5]=0) or MEMWRITE.
  - MEMREAD: mem_req, AdrSrc=1, ResultSrc=00. Wait for mem_done, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite. Go to FETCH.
  - MEMWRITE: mem_req, AdrSrc=1, ResultSrc=00. MemWrite is held for the whole state. Go to FETCH on mem_done.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl decoded from funct3/funct7b5. Go to ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, immsrc=I, ALUControl decoded. funct7b5 is honoured only for shift-right (srai). Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite. Go to FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, SUB, ResultSrc=00. PCWrite = taken. Go to FETCH. Taken condition by funct3:
    - 000: Zero
    - 001: !Zero
    - 100: Neg^Ovf
    - 101: !(Neg^Ovf)
    - 110: !Carry
    - 111: Carry
    - 010 / 011: not taken
  - JAL: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=00, PCWrite. Go to ALUWB (writes OldPC+4).
  - JALR: ALUSrcA=10, ALUSrcB=01, immsrc=I, ADD, ResultSrc=10, PCWrite. ALUOut captures the target; the datapath clears bit0. Go to JALWB.
  - JALWB: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, RegWrite. Go to FETCH.
  - UI: immsrc=U, ALUSrcB=01, ADD; ALUSrcA=11 for lui, 01 for auipc. Go to ALUWB.
- ALUControl encoding:
  - ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001.
  - Upper bits are zero when ALUCTRL_W > 4.

Optional Feature:
ILLEGAL_TRAP_EN:
- Defined: an unknown opcode in DECODE goes to state TRAP. TRAP asserts illegal=1 and drives every strobe to 0, and stays there until reset.
- Undefined: an unknown opcode returns to FETCH (executed as a nop, PC already advanced) and illegal is tied to 0.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum typedef;
  - ALUControl localparams;
  - immsrc, ResultSrc and ALUSrcA/B encodings;
  - opcode constants.
- Sub-module aludec_mc: combinational funct3/funct7b5/op class -> ALUControl. The FSM, wait counter and branch evaluation stay in the top module.

Test Plan:
- add x3,x1,x2 with USE_READY=1, mem_ready stalled 2 cycles in FETCH -> IRWrite/PCWrite only on the ready cycle; state path FETCH(x3), DECODE, EXECR, ALUWB; RegWrite pulses once.
- lw with USE_READY=0, MEM_LAT=3 -> MEMREAD lasts exactly 3 cycles, then MEMWB with ResultSrc=01 and RegWrite=1.
- Branches:
  - bne with Zero=1 -> PCWrite=0 in BRANCH.
  - blt with Neg=1, Ovf=0 -> PCWrite=1.
  - bgeu with Carry=0 -> PCWrite=0.
- jalr x1,8(x2) -> JALR has PCWrite=1 with ResultSrc=10; JALWB has RegWrite=1 with ALUSrcA=01, ALUSrcB=10.
- sw with reset asserted mid-MEMWRITE -> MemWrite drops the same cycle, state returns to FETCH, no RegWrite.
- op=0000000 -> ILLEGAL_TRAP_EN defined: illegal=1, stuck in TRAP, all strobes 0; undefined: back to FETCH next cycle, illegal=0.
